serial_mag_comp: RTL and testbench
==================================

Name: serial_mag_comp

Overview:
- Multi-bit magnitude comparator built around the 1-bit compare cell. It sits directly downstream of that cell's G/E/L bit equations.
- It accepts two WIDTH-bit unsigned operands on a start strobe and compares one bit per clock, MSB first.
- It folds each per-bit G/E/L into a sticky running result and reports the final gt/eq/lt with a one-cycle done pulse.
- It is an area-cheap alternative to a WIDTH-wide parallel comparator, for control paths where latency is acceptable.

Parameters:
- WIDTH, 8: operand width in bits; legal range 1 to 64.
- EARLY_EXIT, 0: 1 means finish as soon as the first differing bit decides the result; 0 means always take WIDTH compare cycles.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request; accepted on an edge where start=1 and busy=0.
- a  input  WIDTH  operand A; sampled only on the accept edge.
- b  input  WIDTH  operand B; sampled only on the accept edge.
- busy  output  1  high while bits are being compared (RUN state).
- done  output  1  one-cycle pulse; the result is final while done=1.
- gt  output  1  A > B (running value during RUN, final value at done).
- eq  output  1  A == B.
- lt  output  1  A < B.

Behaviour:
- Reset state: state=IDLE, busy=0, done=0, gt=0, eq=1, lt=0, shift registers and bit counter cleared.
- Reset has priority over every other event. An rst during RUN aborts the compare: no done pulse, outputs return to reset values, start is ignored on that edge.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE or DONE with start=1 (accept edge E0):
  - load a and b into shift registers sa and sb;
  - load bit counter = WIDTH-1;
  - set gt=0, eq=1, lt=0, busy=1, done=0;
  - go to RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE with done=0. Results are held.
- RUN, each edge Ek (k = 1..WIDTH) processes bit WIDTH-k:
  - bit cell on the shift-register MSBs: bg = sa_msb & ~sb_msb; bl = ~sa_msb & sb_msb.
  - update only if eq=1 (sticky): bg=1 gives gt=1, eq=0; bl=1 gives lt=1, eq=0; otherwise unchanged.
  - sa and sb shift left by 1 and the counter decrements.
- RUN termination:
  - if counter==0 on this edge, or (EARLY_EXIT=1 and this bit differs), go to DONE with done=1, busy=0.
  - otherwise stay in RUN.
- Latency:
  - EARLY_EXIT=0: done rises at edge E_WIDTH.
  - EARLY_EXIT=1: done rises at edge E(n+1), where n is the index from the MSB of the first differing bit (n=0 is the MSB). Equal operands still take WIDTH cycles.
- start while busy=1 is ignored and not queued.
- start during the DONE cycle is accepted, giving back-to-back operation with no idle bubble.
- Operands a and b may change freely after the accept edge without affecting the compare in progress.
- gt/eq/lt hold their value from done until the next accept edge.
- Invariant: exactly one of gt, eq, lt is 1 in every cycle, including reset.
- WIDTH=1: a single RUN cycle; done rises at E1.

Test Plan:
- WIDTH=8, EARLY_EXIT=0, a=8'hA5, b=8'hA5, start pulse -> busy high for 8 cycles; done at E8 with eq=1, gt=0, lt=0; done low at E9 with results held.
- WIDTH=8, EARLY_EXIT=0, a=8'h80, b=8'h7F -> gt=1 from E1 onward; done at E8 with gt=1; later LSBs (a=0, b=1) do not flip the result.
- WIDTH=8, EARLY_EXIT=1, a=8'h12, b=8'h13 -> done at E8, lt=1. Then a=8'h40, b=8'h00 -> first difference at n=1, done at E2, gt=1.
- Back-to-back: start held high continuously with a new operand pair each accept -> accepts at E0 and at the DONE cycle; start during RUN ignored; results match a software compare for 1000 random pairs.
- rst asserted at E3 of a compare -> next cycle busy=0, done=0, eq=1; no done pulse; the next start runs a full, correct compare.
- WIDTH=1, all four (a,b) pairs -> done at E1 with (gt,eq,lt) = 010, 001, 100, 010 for (0,0), (0,1), (1,0), (1,1).

Source files
------------

// File: rtl/serial_mag_comp_if.sv
// Operand/result bundle for the bit-serial magnitude comparator.
// The master drives a request; the slave returns status and the running result.
interface serial_mag_comp_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output start, a, b,
        input  busy, done, gt, eq, lt
    );

    modport slave (
        input  start, a, b,
        output busy, done, gt, eq, lt
    );
endinterface

// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator: one bit per clock, MSB first,
// folding the per-bit G/E/L cell into a sticky gt/eq/lt result.
module serial_mag_comp #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    serial_mag_comp_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             bg, bl;

    // 1-bit compare cell on the current MSBs
    assign bg = sa_q[WIDTH-1] & ~sb_q[WIDTH-1];
    assign bl = ~sa_q[WIDTH-1] & sb_q[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Only the first differing bit may decide; later bits are ignored
                if (eq_q) begin
                    if (bg) begin
                        gt_d = 1'b1;
                        eq_d = 1'b0;
                    end else if (bl) begin
                        lt_d = 1'b1;
                        eq_d = 1'b0;
                    end
                end
                sa_d  = sa_q << 1;
                sb_d  = sb_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if ((cnt_q == '0) || (EARLY_EXIT && (bg || bl))) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == S_RUN);
        bus.done = (state_q == S_DONE);
        bus.gt   = gt_q;
        bus.eq   = eq_q;
        bus.lt   = lt_q;
    end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed + randomized bench for serial_mag_comp in three configurations:
// 8-bit full-length, 8-bit early-exit, and 1-bit.
module tb_serial_mag_comp;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_mag_comp_if #(.WIDTH(8)) if8  ();
    serial_mag_comp_if #(.WIDTH(8)) if8e ();
    serial_mag_comp_if #(.WIDTH(1)) if1  ();

    serial_mag_comp #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_full  (.clk(clk), .rst(rst), .bus(if8));
    serial_mag_comp #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_early (.clk(clk), .rst(rst), .bus(if8e));
    serial_mag_comp #(.WIDTH(1), .EARLY_EXIT(1'b0)) u_one   (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // {busy, done, gt, eq, lt}
    function automatic logic [4:0] obs(input int s);
        case (s)
            0:       return {if8.busy,  if8.done,  if8.gt,  if8.eq,  if8.lt};
            1:       return {if8e.busy, if8e.done, if8e.gt, if8e.eq, if8e.lt};
            default: return {if1.busy,  if1.done,  if1.gt,  if1.eq,  if1.lt};
        endcase
    endfunction

    function automatic int wid(input int s);
        return (s == 2) ? 1 : 8;
    endfunction

    // Cycles from accept to done, straight from the termination rule
    function automatic int exp_lat(input int w, input bit ee, input logic [7:0] av, input logic [7:0] bv);
        if (!ee) return w;
        for (int n = 0; n < w; n++) begin
            if (av[w-1-n] != bv[w-1-n]) return n + 1;
        end
        return w;
    endfunction

    task automatic set_in(input int s, input bit st, input logic [7:0] av, input logic [7:0] bv);
        case (s)
            0: begin if8.start = st;  if8.a = av;  if8.b = bv;  end
            1: begin if8e.start = st; if8e.a = av; if8e.b = bv; end
            default: begin if1.start = st; if1.a = av[0]; if1.b = bv[0]; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Caller has already driven start/a/b so the next rising edge is the accept.
    task automatic run_cmp(input int s, input logic [7:0] av_in, input logic [7:0] bv_in,
                           input bit chain, input logic [7:0] nav, input logic [7:0] nbv);
        int         w;
        int         lat;
        logic [7:0] av, bv, ra, rb;
        logic [4:0] o;
        logic [2:0] er;
        w   = wid(s);
        av  = (w == 1) ? {7'b0, av_in[0]} : av_in;
        bv  = (w == 1) ? {7'b0, bv_in[0]} : bv_in;
        lat = exp_lat(w, s == 1, av, bv);
        er  = 3'b010;
        @(posedge clk); #1;
        o = obs(s);
        chk("accept", 32'(o), 32'(5'b10_010));
        set_in(s, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            o  = obs(s);
            ra = av >> (w - k);
            rb = bv >> (w - k);
            er = {ra > rb, ra == rb, ra < rb};
            chk("onehot", 32'($countones(o[2:0])), 32'd1);
            chk("result", 32'(o[2:0]), 32'(er));
            if (k < lat) begin
                chk("run", 32'(o[4:3]), 32'(2'b10));
                set_in(s, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            end else begin
                chk("done", 32'(o[4:3]), 32'(2'b01));
                if (chain) set_in(s, 1'b1, nav, nbv);
                else       set_in(s, 1'b0, 8'($urandom), 8'($urandom));
            end
        end
        if (!chain) begin
            @(posedge clk); #1;
            o = obs(s);
            chk("idle", 32'(o[4:3]), 32'(2'b00));
            chk("held", 32'(o[2:0]), 32'(er));
        end
    endtask

    initial begin
        logic [7:0] ca, cb, na, nb;
        logic [1:0] pr;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        for (int s = 0; s < 3; s++) set_in(s, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) chk("reset", 32'(obs(s)), 32'(5'b00_010));
        rst = 1'b0;

        set_in(0, 1'b1, 8'hA5, 8'hA5);  run_cmp(0, 8'hA5, 8'hA5, 1'b0, 8'h00, 8'h00);
        set_in(0, 1'b1, 8'h80, 8'h7F);  run_cmp(0, 8'h80, 8'h7F, 1'b0, 8'h00, 8'h00);
        set_in(1, 1'b1, 8'h12, 8'h13);  run_cmp(1, 8'h12, 8'h13, 1'b0, 8'h00, 8'h00);
        set_in(1, 1'b1, 8'h40, 8'h00);  run_cmp(1, 8'h40, 8'h00, 1'b0, 8'h00, 8'h00);
        set_in(1, 1'b1, 8'h5A, 8'h5A);  run_cmp(1, 8'h5A, 8'h5A, 1'b0, 8'h00, 8'h00);

        for (int p = 0; p < 4; p++) begin
            pr = 2'(p);
            set_in(2, 1'b1, {7'b0, pr[1]}, {7'b0, pr[0]});
            run_cmp(2, {7'b0, pr[1]}, {7'b0, pr[0]}, 1'b0, 8'h00, 8'h00);
        end

        // Back-to-back: each done cycle accepts the next pair
        for (int s = 0; s < 3; s++) begin
            ca = 8'($urandom);
            cb = (s == 0) ? ca : 8'($urandom);
            set_in(s, 1'b1, ca, cb);
            for (int i = 0; i < ((s == 0) ? 1000 : 200); i++) begin
                na = 8'($urandom);
                nb = ($urandom_range(0, 7) == 0) ? na : 8'($urandom);
                run_cmp(s, ca, cb, (i < ((s == 0) ? 999 : 199)), na, nb);
                ca = na;
                cb = nb;
            end
        end

        // Reset in the middle of a compare aborts it and blocks a same-edge start
        set_in(0, 1'b1, 8'h3C, 8'h3D);
        @(posedge clk); #1;
        set_in(0, 1'b0, 8'h00, 8'h00);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        set_in(0, 1'b1, 8'hFF, 8'h00);
        @(posedge clk); #1;
        chk("abort", 32'(obs(0)), 32'(5'b00_010));
        rst = 1'b0;
        set_in(0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("no_done", 32'(obs(0)), 32'(5'b00_010));
        end
        set_in(0, 1'b1, 8'h3C, 8'h3D);  run_cmp(0, 8'h3C, 8'h3D, 1'b0, 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
